gray_wptr_gen: RTL
==================

Name: gray_wptr_gen

Overview:
- Write-side pointer and full-flag generator for the async FIFO.
- Holds the binary write pointer and drives the Gray-coded write pointer (binary→Gray) across to the read domain.
- Synchronises the incoming Gray read pointer and derives full/overflow.
- Counterpart of the Gray→binary read-side conversion: this block produces the Gray code that the read side consumes.

Parameters:
- ADDR_WIDTH, 4, FIFO address width; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- SYNC_STAGES, 2, flops in the rgray_i synchroniser; legal range >= 2.
- AF_MARGIN, 2, almost-full threshold margin; used only with the optional feature.

Ports:
- clk_i  input  1  write-domain clock
- rst_i  input  1  synchronous active-high reset
- wr_en_i  input  1  write request
- rgray_i  input  ADDR_WIDTH+1  Gray read pointer from read domain (asynchronous)
- wr_ack_o  output  1  write accepted this cycle (combinational: wr_en_i & ~full_o)
- waddr_o  output  ADDR_WIDTH  RAM write address = wbin[ADDR_WIDTH-1:0]
- wgray_o  output  ADDR_WIDTH+1  registered Gray write pointer
- full_o  output  1  registered full flag
- overflow_o  output  1  one-cycle pulse: write attempted while full

Behaviour:
- Reset (rst_i=1 at clk_i edge) zeroes:
  - wbin, wgray_o, full_o, overflow_o
  - all synchroniser stages
- Reset overrides wr_en_i; a write presented in a reset cycle is discarded.
- Accept condition: wr_en_i & ~full_o.
  - On accept: wbin <= wbin+1, wrapping modulo 2**(ADDR_WIDTH+1).
  - wgray_o <= wbin_next ^ (wbin_next >> 1), registered in the same edge as wbin.
- wgray_o is a flop output only, never combinational, so exactly one bit changes per increment.
- Synchroniser: rgray_i → SYNC_STAGES flop chain → rgray_s.
  - No logic between stages.
  - rgray_s is used only in Gray form, except under the optional feature.
- Full: full_o <= (wgray_next == {~rgray_s[MSB:MSB-1], rgray_s[MSB-2:0]}).
  - wgray_next is the post-update Gray value.
  - Full asserts on the same edge as the write that fills the FIFO; no extra latency.
- Full deassert latency after rgray_i changes: SYNC_STAGES+1 clk_i edges. Pessimistic by design.
- Overflow: wr_en_i & full_o → overflow_o = 1 for that single next cycle.
  - Pointer unchanged.
  - Back-to-back refused writes give consecutive pulses.
- Wrap: wbin 2**(ADDR_WIDTH+1)-1 → 0 and wgray_o → 0; no special handling.
- Simultaneous write and read-pointer change: the write uses the current rgray_s. The new read value affects full only after synchronisation.
- Empty-side logic is out of scope.

Optional Feature:
- Macro: GRAY_WPTR_LEVEL_EN.
- Enabled adds ports:
  - wlevel_o, output, ADDR_WIDTH+1: registered fill level
  - almost_full_o, output, 1: registered almost-full flag
- Enabled behaviour:
  - rbin_s = Gray→binary conversion of rgray_s (MSB copied; bit i = g[i] ^ b[i+1]).
  - wlevel_o <= wbin_next - rbin_s, modulo 2**(ADDR_WIDTH+1).
  - almost_full_o <= (wlevel_next >= 2**ADDR_WIDTH - AF_MARGIN).
  - Both reset to 0 and update on the same edge as full_o.
- Disabled: ports and logic absent; remaining behaviour identical.

Test Plan (ADDR_WIDTH=4, SYNC_STAGES=2):
- Reset: rst_i=1 for 3 cycles with wr_en_i=1 → waddr_o=0, wgray_o=5'b00000, full_o=0, overflow_o=0.
- Fill: rgray_i=0, 16 consecutive writes.
  - After write 3: wgray_o=5'b00010.
  - After write 16: wgray_o=5'b11000, full_o=1 on that same edge, waddr_o=0.
- Overflow: write 17 while full → wgray_o stays 5'b11000, wr_ack_o=0, overflow_o=1 for exactly one cycle.
- Drain release: from full, set rgray_i=5'b00001 → full_o=0 exactly 3 edges later; next write accepted, wgray_o=5'b11001.
- Wrap: 32 writes with rgray_i following wgray_o two cycles later.
  - wbin passes 31→0; wgray_o goes 5'b10000→5'b00000.
  - full_o never asserts, overflow_o stays 0.
- GRAY_WPTR_LEVEL_EN, AF_MARGIN=2, rgray_i=0:
  - 10 writes → wlevel_o=10, almost_full_o=0.
  - 14 writes → almost_full_o=1.
  - 16 writes → wlevel_o=16, full_o=1.

Source files
------------

// File: rtl/gray_wptr_gen.sv
// gray_wptr_gen
// -----------------------------------------------------------------------------
// Write-side pointer and full-flag generator for an asynchronous FIFO.
// Keeps the binary write pointer, publishes a registered Gray-coded copy of it
// to the read domain, synchronises the incoming Gray read pointer and derives
// the full / overflow flags from it.
//
// Optional feature (macro GRAY_WPTR_LEVEL_EN): adds a registered fill level and
// an almost-full flag computed from the synchronised read pointer. With the
// macro undefined the extra ports, the AF_MARGIN parameter and their logic are
// absent.
//
// Ports:
//   clk_i          write-domain clock
//   rst_i          synchronous active-high reset
//   wr_en_i        write request
//   rgray_i        Gray read pointer from the read domain (asynchronous)
//   wr_ack_o       write accepted this cycle (wr_en_i & ~full_o, combinational)
//   waddr_o        RAM write address (low ADDR_WIDTH bits of the binary pointer)
//   wgray_o        registered Gray write pointer
//   full_o         registered full flag
//   overflow_o     one-cycle pulse after a write attempted while full
//   wlevel_o       (GRAY_WPTR_LEVEL_EN) registered fill level
//   almost_full_o  (GRAY_WPTR_LEVEL_EN) registered almost-full flag
// -----------------------------------------------------------------------------
module gray_wptr_gen #(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2
`ifdef GRAY_WPTR_LEVEL_EN
    ,
    parameter int AF_MARGIN   = 2
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH:0]   rgray_i,
    output logic                  wr_ack_o,
    output logic [ADDR_WIDTH-1:0] waddr_o,
    output logic [ADDR_WIDTH:0]   wgray_o,
    output logic                  full_o,
    output logic                  overflow_o
`ifdef GRAY_WPTR_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   wlevel_o,
    output logic                  almost_full_o
`endif
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] wbin_reg;
    logic [ADDR_WIDTH:0] wbin_next;
    logic [ADDR_WIDTH:0] wgray_reg;
    logic [ADDR_WIDTH:0] wgray_next;
    logic                full_reg;
    logic                full_next;
    logic                overflow_reg;
    logic                overflow_next;
    logic                wr_ack;

    // Read-pointer synchroniser chain; the last stage is the only one used.
    logic [ADDR_WIDTH:0] sync_reg [SYNC_STAGES];
    logic [ADDR_WIDTH:0] rgray_s;

    // Pointer that the local write pointer must equal for the FIFO to be full:
    // the read pointer advanced by one full lap, which in Gray form means the
    // two top bits inverted and the rest unchanged.
    logic [ADDR_WIDTH:0] full_match;

    assign wr_ack = wr_en_i & ~full_reg;

    always_comb begin
        wbin_next = wbin_reg;
        if (wr_ack) begin
            wbin_next = wbin_reg + PTR_ONE;
        end
    end

    // Binary to Gray on the next-state value so that wgray_o itself comes
    // straight from a flop and never glitches across the domain boundary.
    assign wgray_next[ADDR_WIDTH] = wbin_next[ADDR_WIDTH];
    generate
        for (genvar gi = 0; gi < ADDR_WIDTH; gi++) begin : g_bin2gray
            assign wgray_next[gi] = wbin_next[gi] ^ wbin_next[gi+1];
        end
    endgenerate

    assign rgray_s    = sync_reg[SYNC_STAGES-1];
    assign full_match = {~rgray_s[ADDR_WIDTH:ADDR_WIDTH-1], rgray_s[ADDR_WIDTH-2:0]};

    // Full is evaluated against the post-write pointer so it rises on the very
    // edge that stores the last free entry.
    assign full_next     = (wgray_next == full_match);
    assign overflow_next = wr_en_i & full_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= '0;
            end
        end else begin
            sync_reg[0] <= rgray_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wbin_reg     <= '0;
            wgray_reg    <= '0;
            full_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            wbin_reg     <= wbin_next;
            wgray_reg    <= wgray_next;
            full_reg     <= full_next;
            overflow_reg <= overflow_next;
        end
    end

    assign wr_ack_o   = wr_ack;
    assign waddr_o    = wbin_reg[ADDR_WIDTH-1:0];
    assign wgray_o    = wgray_reg;
    assign full_o     = full_reg;
    assign overflow_o = overflow_reg;

`ifdef GRAY_WPTR_LEVEL_EN
    localparam logic [ADDR_WIDTH:0] AF_THRESH =
        (ADDR_WIDTH+1)'((2**ADDR_WIDTH) - AF_MARGIN);

    logic [ADDR_WIDTH:0] rbin_s;
    logic [ADDR_WIDTH:0] wlevel_reg;
    logic [ADDR_WIDTH:0] wlevel_next;
    logic                almost_full_reg;
    logic                almost_full_next;

    // Gray to binary: each binary bit is the XOR of all Gray bits at and above
    // it, written as a reduction so there is no bit-to-bit feedback chain.
    generate
        for (genvar gi = 0; gi <= ADDR_WIDTH; gi++) begin : g_gray2bin
            assign rbin_s[gi] = ^rgray_s[ADDR_WIDTH:gi];
        end
    endgenerate

    // Modular subtraction yields the level directly, including across wrap.
    assign wlevel_next      = wbin_next - rbin_s;
    assign almost_full_next = (wlevel_next >= AF_THRESH);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wlevel_reg      <= '0;
            almost_full_reg <= 1'b0;
        end else begin
            wlevel_reg      <= wlevel_next;
            almost_full_reg <= almost_full_next;
        end
    end

    assign wlevel_o      = wlevel_reg;
    assign almost_full_o = almost_full_reg;
`endif

endmodule
